lcd_write_scheduler: RTL and testbench
======================================

# lcd_write_scheduler

Byte-level write controller for the 4-bit HD44780-style dot-matrix LCD bus. It owns the bus after the power-on nibble initialiser reports completion, accepts command/data bytes over a valid/ready handshake, and splits each byte into two enable-strobed nibbles. After each byte it waits out the controller's execution time. Until initialisation completes it passes the initialiser's RS/E/data straight through to the pins, so it is the single driver of the LCD bus.

## Interface
- SETUP_CYC, 4: cycles RS/data are stable before E rises (min 1)
- E_HIGH_CYC, 50: E high width in cycles (min 1)
- E_LOW_CYC, 50: E low time after each pulse (min 1)
- EXEC_CYC, 4000: post-byte wait for normal commands and data (40 µs at 100 MHz)
- LONG_EXEC_CYC, 160000: post-byte wait for clear/home commands (1.6 ms)
- CNT_W, 18: delay counter width; must hold max(all delay params)

- clk  in  1  system clock, 100 MHz
- nrst  in  1  reset; asynchronous assert, active-low
- init_done  in  1  initialiser finished; scheduler owns bus while high
- RS_init  in  1  initialiser RS
- E_init  in  1  initialiser E
- data_bits  in  4  initialiser nibble
- req_valid  in  1  write request present
- req_rs  in  1  0 = command, 1 = data
- req_data  in  8  byte to write
- req_ready  out  1  request accepted on the clock edge where valid and ready are both high
- busy  out  1  transaction in progress (state != IDLE)
- lcd_rs  out  1  LCD RS pin
- lcd_e  out  1  LCD E pin
- lcd_d  out  4  LCD DB7..DB4

## Operation
- Bus mux is combinational: init_done=0 → lcd_rs/lcd_e/lcd_d = RS_init/E_init/data_bits; init_done=1 → internal registers.
- Reset: state IDLE, internal rs/e/d registers 0, counter 0, captured byte 0. busy=0. req_ready = init_done.
- req_ready = (state==IDLE) && init_done, combinational. Requests are never accepted while init_done=0.
- States: IDLE → SETUP_H → PULSE_H → GAP_H → SETUP_L → PULSE_L → GAP_L → EXEC → IDLE.
- Accept: capture req_rs and req_data. Drive rs register = req_rs and d register = req_data[7:4]. Load counter. Enter SETUP_H.
- Each timed state lasts exactly its parameter in cycles: SETUP_* = SETUP_CYC, PULSE_* = E_HIGH_CYC, GAP_* = E_LOW_CYC, EXEC = selected wait. The counter reloads on every state entry.
- e register is 1 only in PULSE_H and PULSE_L. RS and nibble stay constant through each pulse and its gap.
- GAP_H → SETUP_L transition drives d = captured[3:0]. d holds the low nibble until the next accept.
- EXEC wait is LONG_EXEC_CYC when captured rs=0 and byte ∈ {0x01, 0x02, 0x03}; otherwise EXEC_CYC.
- Abort: init_done falling in any non-IDLE state → next edge state=IDLE, e=0. The byte is dropped with no retry. The mux hands the bus back to the initialiser the same cycle.
- Valid held high across EXEC→IDLE: the next byte is accepted on the first IDLE cycle, with no dead cycle beyond IDLE itself.

## Timing
Let accept edge = t0, S = SETUP_CYC, H = E_HIGH_CYC, L = E_LOW_CYC, X = selected exec wait.
- lcd_rs and high nibble valid from t0.
- lcd_e high during [t0+S, t0+S+H).
- Low nibble valid from t0+S+H+L.
- lcd_e high during [t0+2S+H+L, t0+2S+2H+L).
- State IDLE and req_ready=1 (if init_done) at t0+2(S+H+L)+X.
- busy=1 during [t0, t0+2(S+H+L)+X).
- Async reset mid-pulse drops lcd_e to 0 immediately, without waiting for a clock edge.

## Test plan
Bench parameters: S=2, H=3, L=3, EXEC_CYC=5, LONG_EXEC_CYC=20.
- Reset plus passthrough: nrst=0 → busy=0, internal e=0. With init_done=0, toggle E_init/data_bits=4'b0011 → lcd_e/lcd_d follow in the same cycle. req_valid=1 → req_ready stays 0 and nothing is accepted.
- Data write: init_done=1, accept rs=1, byte 0x48 at t0.
  - lcd_d=4'h4 and lcd_rs=1 from t0; lcd_e high t0+2..t0+4.
  - lcd_d=4'h8 from t0+8; lcd_e high t0+10..t0+12.
  - req_ready returns at t0+21.
- Clear command: rs=0, byte 0x01 → identical pulse pattern; req_ready returns at t0+36. Byte 0x28 with rs=0 → returns at t0+21.
- Back-to-back: req_valid held with bytes 0x41 then 0x42 → second accept exactly at t0+21, with exactly 4 E pulses total.
- Abort: drop init_done at t0+9 → state IDLE next edge, no second E pulse from scheduler, bus shows init inputs. Byte 0x41 is not retried after init_done returns.
- Async reset at t0+3 during lcd_e=1 → lcd_e=0 immediately, busy=0. After release, a new accept behaves as in the data-write scenario.

Source files
------------

// File: rtl/lcd_write_scheduler.sv
// Byte write scheduler for a 4-bit HD44780-style LCD bus.
// Passes the initialiser through until init_done, then strobes each byte out as two timed nibbles.
module lcd_write_scheduler #(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned E_HIGH_CYC    = 50,
  parameter int unsigned E_LOW_CYC     = 50,
  parameter int unsigned EXEC_CYC      = 4000,
  parameter int unsigned LONG_EXEC_CYC = 160000,
  parameter int unsigned CNT_W         = 18
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       init_done,
  input  logic       RS_init,
  input  logic       E_init,
  input  logic [3:0] data_bits,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP_H = 3'd1;
  localparam logic [2:0] PULSE_H = 3'd2;
  localparam logic [2:0] GAP_H   = 3'd3;
  localparam logic [2:0] SETUP_L = 3'd4;
  localparam logic [2:0] PULSE_L = 3'd5;
  localparam logic [2:0] GAP_L   = 3'd6;
  localparam logic [2:0] EXEC    = 3'd7;

  // Counter runs down from (duration - 1) so each state lasts exactly its duration.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(E_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [3:0]       d_q, d_d;
  logic             cap_rs_q, cap_rs_d;
  logic [7:0]       cap_data_q, cap_data_d;
  logic             cnt_zero;
  logic             long_exec;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      e_q        <= 1'b0;
      d_q        <= 4'h0;
      cap_rs_q   <= 1'b0;
      cap_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      e_q        <= e_d;
      d_q        <= d_d;
      cap_rs_q   <= cap_rs_d;
      cap_data_q <= cap_data_d;
    end
  end

  assign cnt_zero  = (cnt_q == '0);
  // Clear display and return home need the long execution time.
  assign long_exec = !cap_rs_q &&
                     (cap_data_q == 8'h01 || cap_data_q == 8'h02 || cap_data_q == 8'h03);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    e_d        = e_q;
    d_d        = d_q;
    cap_rs_d   = cap_rs_q;
    cap_data_d = cap_data_q;
    if (state_q != IDLE && !init_done) begin
      // Losing the bus drops the byte outright.
      state_d = IDLE;
      e_d     = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && init_done) begin
            cap_rs_d   = req_rs;
            cap_data_d = req_data;
            rs_d       = req_rs;
            d_d        = req_data[7:4];
            cnt_d      = SETUP_LD;
            state_d    = SETUP_H;
          end
        end
        SETUP_H, SETUP_L: begin
          if (cnt_zero) begin
            state_d = (state_q == SETUP_H) ? PULSE_H : PULSE_L;
            e_d     = 1'b1;
            cnt_d   = HIGH_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PULSE_H, PULSE_L: begin
          if (cnt_zero) begin
            state_d = (state_q == PULSE_H) ? GAP_H : GAP_L;
            e_d     = 1'b0;
            cnt_d   = LOW_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP_H: begin
          if (cnt_zero) begin
            state_d = SETUP_L;
            d_d     = cap_data_q[3:0];
            cnt_d   = SETUP_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP_L: begin
          if (cnt_zero) begin
            state_d = EXEC;
            cnt_d   = long_exec ? LONG_LD : EXEC_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        EXEC: begin
          if (cnt_zero) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          e_d     = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && init_done;
  assign busy      = (state_q != IDLE);

  // Single driver of the LCD pins: initialiser until init_done, scheduler afterwards.
  assign lcd_rs = init_done ? rs_q : RS_init;
  assign lcd_e  = init_done ? e_q  : E_init;
  assign lcd_d  = init_done ? d_q  : data_bits;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Randomised and directed bench for lcd_write_scheduler against a timeline-based reference model.
module tb_lcd_write_scheduler;

  localparam int S  = 2;
  localparam int H  = 3;
  localparam int L  = 3;
  localparam int XN = 5;
  localparam int XL = 20;

  logic       clk = 1'b0;
  logic       nrst;
  logic       init_done;
  logic       RS_init;
  logic       E_init;
  logic [3:0] data_bits;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_e;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_write_scheduler #(
    .SETUP_CYC(S), .E_HIGH_CYC(H), .E_LOW_CYC(L),
    .EXEC_CYC(XN), .LONG_EXEC_CYC(XL), .CNT_W(18)
  ) dut (
    .clk(clk), .nrst(nrst), .init_done(init_done),
    .RS_init(RS_init), .E_init(E_init), .data_bits(data_bits),
    .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulses = 0;
  logic prev_e = 1'b0;

  // Reference model: an active byte is a timeline measured from its accept edge.
  logic       m_active = 1'b0;
  int         m_t0 = 0;
  int         m_x = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       hold_rs = 1'b0;
  logic [3:0] hold_d = 4'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    hold_rs  = 1'b0;
    hold_d   = 4'h0;
  endtask

  // Check one cycle against the model, then advance model and clock one edge.
  task automatic tick();
    logic e_m, rs_m, busy_m, rdy_m;
    logic [3:0] d_m;
    int rel;
    #1;
    rel = cyc - m_t0;
    if (m_active) begin
      e_m    = (rel >= S && rel < S + H) || (rel >= 2*S + H + L && rel < 2*S + 2*H + L);
      d_m    = (rel < S + H + L) ? m_byte[7:4] : m_byte[3:0];
      rs_m   = m_rs;
      busy_m = 1'b1;
    end else begin
      e_m    = 1'b0;
      d_m    = hold_d;
      rs_m   = hold_rs;
      busy_m = 1'b0;
    end
    rdy_m = !m_active && init_done;
    check_val("busy", 32'(busy), 32'(busy_m));
    check_val("req_ready", 32'(req_ready), 32'(rdy_m));
    if (init_done) begin
      check_val("lcd_e", 32'(lcd_e), 32'(e_m));
      check_val("lcd_d", 32'(lcd_d), 32'(d_m));
      check_val("lcd_rs", 32'(lcd_rs), 32'(rs_m));
      if (lcd_e && !prev_e) pulses++;
      prev_e = lcd_e;
    end else begin
      check_val("pass_e", 32'(lcd_e), 32'(E_init));
      check_val("pass_d", 32'(lcd_d), 32'(data_bits));
      check_val("pass_rs", 32'(lcd_rs), 32'(RS_init));
      prev_e = 1'b0;
    end
    if (!nrst) begin
      model_reset();
    end else if (m_active) begin
      if (!init_done) begin
        m_active = 1'b0;
        hold_d   = d_m;
        hold_rs  = rs_m;
      end else if (rel + 1 >= 2*(S + H + L) + m_x) begin
        m_active = 1'b0;
        hold_d   = m_byte[3:0];
        hold_rs  = m_rs;
      end
    end else if (req_valid && init_done) begin
      m_active = 1'b1;
      m_t0     = cyc + 1;
      m_rs     = req_rs;
      m_byte   = req_data;
      m_x      = (!req_rs && (req_data == 8'h01 || req_data == 8'h02 || req_data == 8'h03)) ? XL : XN;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (req_ready) break;
      tick();
    end
  endtask

  // One handshake, then check the cycle at which the scheduler is ready again.
  task automatic do_write(input string tag, input logic rs, input logic [7:0] b, input int exp_lat);
    int t0;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = b;
    tick();
    t0 = cyc;
    req_valid = 1'b0;
    wait_ready(100);
    check_val(tag, 32'(cyc - t0), 32'(exp_lat));
  endtask

  int t0;
  int id_hold;
  logic [7:0] picks [6];

  initial begin
    picks[0] = 8'h01; picks[1] = 8'h02; picks[2] = 8'h03;
    picks[3] = 8'h28; picks[4] = 8'h48; picks[5] = 8'h00;
    nrst = 1'b0; init_done = 1'b0; RS_init = 1'b0; E_init = 1'b0; data_bits = 4'h0;
    req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    #2;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_e_int", 32'(dut.e_q), 32'd0);
    tick();
    E_init = 1'b1; RS_init = 1'b1; data_bits = 4'b0011;
    #1;
    check_val("pass_e_same_cycle", 32'(lcd_e), 32'd1);
    check_val("pass_d_same_cycle", 32'(lcd_d), 32'h3);
    tick();
    nrst = 1'b1;
    req_valid = 1'b1; req_data = 8'h55;
    for (int i = 0; i < 5; i++) tick();
    check_val("no_accept_busy", 32'(busy), 32'd0);
    req_valid = 1'b0; E_init = 1'b0;

    // Data and command writes with their expected turnaround
    init_done = 1'b1;
    tick();
    do_write("lat_data_48", 1'b1, 8'h48, 21);
    do_write("lat_clear_01", 1'b0, 8'h01, 36);
    do_write("lat_cmd_28", 1'b0, 8'h28, 21);
    do_write("lat_home_02", 1'b0, 8'h02, 36);
    do_write("lat_data_03", 1'b1, 8'h03, 21);

    // Back-to-back with valid held
    pulses = 0;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
    tick();
    t0 = cyc;
    req_data = 8'h42;
    wait_ready(60);
    check_val("b2b_accept", 32'(cyc - t0), 32'd21);
    tick();
    req_valid = 1'b0;
    wait_ready(60);
    check_val("b2b_pulses", 32'(pulses), 32'd4);

    // Abort mid-byte by dropping init_done
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
    tick();
    t0 = cyc;
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    init_done = 1'b0; E_init = 1'b1; data_bits = 4'hA;
    tick();
    check_val("abort_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) tick();
    init_done = 1'b1; E_init = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check_val("abort_no_retry", 32'(pulses), 32'd0);

    // Async reset while E is high
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h48;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_val("pre_rst_e", 32'(lcd_e), 32'd1);
    nrst = 1'b0;
    #1;
    check_val("async_rst_e", 32'(lcd_e), 32'd0);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    tick();
    tick();
    nrst = 1'b1;
    tick();
    do_write("lat_after_rst", 1'b1, 8'h48, 21);

    // Randomised traffic with occasional loss of the bus
    id_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (id_hold > 0) begin
        id_hold--;
        init_done = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        id_hold   = int'($urandom_range(0, 29));
        init_done = 1'b0;
      end else begin
        init_done = 1'b1;
      end
      req_valid = 1'($urandom_range(0, 1));
      req_rs    = 1'($urandom_range(0, 1));
      req_data  = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom);
      RS_init   = 1'($urandom_range(0, 1));
      E_init    = 1'($urandom_range(0, 1));
      data_bits = 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
